// File: rtl/pending_encoder16x4.sv
// Registered 16-to-4 encoder with request capture: one-hot events become pending flags,
// which are granted one per cycle through a valid/ready output slot.
module pending_encoder16x4 #(
    parameter int ROUND_ROBIN = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] req,
    input  logic        ready,
    output logic [3:0]  code,
    output logic        valid,
    output logic [15:0] pending,
    output logic        lost
);

    logic [3:0]  ptr;
    logic [3:0]  sel;
    logic        slot_free;
    logic        load;
    logic [15:0] load_mask;
    logic [15:0] req_en;
    logic [15:0] pending_next;
    logic        lost_next;

    assign slot_free = ~valid | ready;
    assign load      = en & ~clr & slot_free & (|pending);
    assign load_mask = load ? (16'h0001 << sel) : 16'h0000;
    assign req_en    = en ? req : 16'h0000;

    // Selection works on the registered pending value only, so a request never
    // bypasses straight into the slot; that keeps the request-to-valid latency at 2.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        logic       found;
        logic [3:0] idx;
        sel   = 4'd0;
        found = 1'b0;
        idx   = 4'd0;
        if (ROUND_ROBIN != 0) begin
            // Scan ptr+1 .. ptr+16 (the last step wraps back onto ptr itself).
            for (int k = 1; k <= 16; k++) begin
                idx = ptr + 4'(k);
                if (!found && pending[idx]) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (pending[i]) sel = 4'(i);
            end
        end
    end

    // A request on the index being loaded this edge is a fresh event, so it is
    // excluded from the collision check and simply re-pends.
    always_comb begin
        pending_next = (pending & ~load_mask) | req_en;
        lost_next    = |(req_en & pending & ~load_mask);
        if (clr) begin
            pending_next = 16'h0000;
            lost_next    = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so all
    // registers sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 16'h0000;
            code    <= 4'd0;
            valid   <= 1'b0;
            lost    <= 1'b0;
            ptr     <= 4'd15;
        end else begin
            pending <= pending_next;
            lost    <= lost_next;
            if (clr) begin
                valid <= 1'b0;
            end else if (load) begin
                code  <= sel;
                valid <= 1'b1;
                ptr   <= sel;
            end else if (slot_free) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pending_encoder16x4.sv
// Directed bench for pending_encoder16x4: one fixed-priority and one round-robin instance
// share stimulus; expected values are hand-computed per step.
module tb_pending_encoder16x4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [15:0] req;
    logic        ready;

    logic [3:0]  fp_code,    rr_code;
    logic        fp_valid,   rr_valid;
    logic [15:0] fp_pending, rr_pending;
    logic        fp_lost,    rr_lost;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pending_encoder16x4 #(.ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .req(req), .ready(ready),
        .code(fp_code), .valid(fp_valid), .pending(fp_pending), .lost(fp_lost)
    );

    pending_encoder16x4 #(.ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .req(req), .ready(ready),
        .code(rr_code), .valid(rr_valid), .pending(rr_pending), .lost(rr_lost)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        req   = 16'h0000;
        ready = 1'b1;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; req = 16'h0000; ready = 1'b0;
        #2;
        rst_n = 1'b1;
        step();

        // Reset between edges while busy
        ready = 1'b0;
        req   = 16'hFFFF;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("rst_pending", fp_pending, 16'h0000);
        check("rst_valid",   fp_valid,   1'b0);
        check("rst_code",    fp_code,    4'd0);
        check("rst_lost",    fp_lost,    1'b0);
        req = 16'h0000;
        #1;
        rst_n = 1'b1;
        req   = 16'h0001;
        step();
        req = 16'h0000;
        check("rst_req_pend",  fp_pending, 16'h0001);
        check("rst_req_valid0", fp_valid,  1'b0);
        step();
        check("rst_req_valid1", fp_valid,  1'b1);
        check("rst_req_code",   fp_code,   4'd0);

        // Fixed priority drain
        do_reset();
        req = 16'h8421;
        step();
        req = 16'h0000;
        check("fp_pend0", fp_pending, 16'h8421);
        check("fp_valid0", fp_valid, 1'b0);
        step(); check("fp_code15", fp_code, 4'd15); check("fp_pend1", fp_pending, 16'h0421);
        step(); check("fp_code10", fp_code, 4'd10); check("fp_pend2", fp_pending, 16'h0021);
        step(); check("fp_code5",  fp_code, 4'd5);  check("fp_pend3", fp_pending, 16'h0001);
        step(); check("fp_code0",  fp_code, 4'd0);  check("fp_valid4", fp_valid, 1'b1);
        step(); check("fp_idle_valid", fp_valid, 1'b0); check("fp_idle_pend", fp_pending, 16'h0000);

        // Backpressure and lost
        do_reset();
        ready = 1'b0;
        req   = 16'h0010;
        step();
        req = 16'h0000;
        step();
        check("bp_valid", fp_valid, 1'b1);
        check("bp_code",  fp_code,  4'd4);
        check("bp_pend0", fp_pending, 16'h0000);
        req = 16'h0010;
        step();
        check("bp_repend", fp_pending, 16'h0010);
        check("bp_nolost", fp_lost, 1'b0);
        step();
        req = 16'h0000;
        check("bp_lost1", fp_lost, 1'b1);
        check("bp_hold_code", fp_code, 4'd4);
        check("bp_hold_valid", fp_valid, 1'b1);
        step();
        check("bp_lost_pulse", fp_lost, 1'b0);
        ready = 1'b1;
        step();
        check("bp_second_valid", fp_valid, 1'b1);
        check("bp_second_code",  fp_code,  4'd4);
        check("bp_second_pend",  fp_pending, 16'h0000);
        step();
        check("bp_done_valid", fp_valid, 1'b0);

        // Round robin with held requests
        do_reset();
        req = 16'h0085;
        step();
        check("rr_pend", rr_pending, 16'h0085);
        step(); check("rr_code_a0", rr_code, 4'd0); check("rr_valid", rr_valid, 1'b1);
        step(); check("rr_code_a2", rr_code, 4'd2);
        step(); check("rr_code_a7", rr_code, 4'd7);
        step(); check("rr_code_b0", rr_code, 4'd0);
        step(); check("rr_code_b2", rr_code, 4'd2);
        step(); check("rr_code_b7", rr_code, 4'd7);
        check("rr_fp_code7", fp_code, 4'd7);
        req = 16'h0000;

        // clr and en
        do_reset();
        ready = 1'b0;
        req   = 16'h0001;
        step();
        req = 16'h0F00;
        step();
        check("clr_pre_valid", fp_valid, 1'b1);
        check("clr_pre_pend",  fp_pending, 16'h0F00);
        clr = 1'b1;
        req = 16'h0001;
        step();
        clr = 1'b0;
        check("clr_pend",  fp_pending, 16'h0000);
        check("clr_valid", fp_valid, 1'b0);
        check("clr_code_hold", fp_code, 4'd0);
        check("clr_lost", fp_lost, 1'b0);
        en  = 1'b0;
        req = 16'h0002;
        step();
        check("en0_pend",  fp_pending, 16'h0000);
        check("en0_valid", fp_valid, 1'b0);
        en  = 1'b1;
        req = 16'h0020;
        step();
        en  = 1'b0;
        req = 16'h0000;
        step();
        check("en0_retain", fp_pending, 16'h0020);
        check("en0_noload", fp_valid, 1'b0);
        en  = 1'b1;
        step();
        check("en1_load_code", fp_code, 4'd5);
        en    = 1'b0;
        ready = 1'b1;
        step();
        check("en0_handshake", fp_valid, 1'b0);
        en = 1'b1;

        // Re-request of the index being loaded
        do_reset();
        req = 16'h0008;
        step();
        check("sim_pend0", fp_pending, 16'h0008);
        step();
        req = 16'h0000;
        check("sim_code", fp_code, 4'd3);
        check("sim_repend", fp_pending, 16'h0008);
        check("sim_lost", fp_lost, 1'b0);
        step();
        check("sim_code2", fp_code, 4'd3);
        check("sim_valid2", fp_valid, 1'b1);
        check("sim_pend2", fp_pending, 16'h0000);
        step();
        check("sim_done", fp_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
